// File: rtl/alu_pkg.sv
// Shared opcodes, FSM state encoding and latency helper for the iterative ALU.
package alu_pkg;

  localparam logic [1:0] OP_ADD = 2'b00;
  localparam logic [1:0] OP_SUB = 2'b01;
  localparam logic [1:0] OP_MUL = 2'b10;
  localparam logic [1:0] OP_DIV = 2'b11;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    BUSY = 2'd1,
    DONE = 2'd2
  } state_t;

  // Cycles from accept to result: the iterative ops take one cycle per operand bit.
  function automatic int op_latency(input logic [1:0] op, input logic b_zero, input int w);
    if (op == OP_MUL || (op == OP_DIV && !b_zero)) return w;
    return 1;
  endfunction

endpackage

// File: rtl/muldiv_iter_core.sv
// One-bit-per-cycle shift-add multiplier and restoring divider sharing one accumulator.
module muldiv_iter_core
  import alu_pkg::*;
#(
  parameter int W = 8
) (
  input  logic           clk,
  input  logic           rst,
  input  logic           start,
  input  logic [1:0]     op,
  input  logic [W-1:0]   a,
  input  logic [W-1:0]   b,
  output logic           done,
  output logic [2*W-1:0] result,
  output logic [W-1:0]   remainder
);

  localparam int CW = $clog2(W + 1);

  logic          run;
  logic [CW-1:0] cnt;
  logic          launch;
  logic          is_div;
  logic [2*W-1:0] acc;
  logic [2*W-1:0] mcand;
  logic [W-1:0]   opb;
  logic [W:0]     rem_sh;
  logic [W-1:0]   rem_sub;
  logic           fits;

  assign launch = start && (op == OP_MUL || (op == OP_DIV && b != '0));

  // Divide keeps the partial remainder in acc[2W-1:W] and the quotient bits in acc[W-1:0].
  always_comb begin
    rem_sh  = {acc[2*W-1:W], acc[W-1]};
    fits    = rem_sh >= {1'b0, opb};
    rem_sub = rem_sh[W-1:0] - opb;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      run  <= 1'b0;
      cnt  <= '0;
      done <= 1'b0;
    end else if (start) begin
      run  <= launch;
      cnt  <= launch ? CW'(W) : '0;
      done <= 1'b0;
    end else if (run) begin
      cnt <= cnt - CW'(1);
      if (cnt == CW'(1)) begin
        run  <= 1'b0;
        done <= 1'b1;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (start) begin
      is_div <= (op == OP_DIV);
      acc    <= (op == OP_DIV) ? {{W{1'b0}}, a} : '0;
      mcand  <= {{W{1'b0}}, a};
      opb    <= b;
    end else if (run) begin
      if (is_div) begin
        acc <= fits ? {rem_sub, acc[W-2:0], 1'b1} : {rem_sh[W-1:0], acc[W-2:0], 1'b0};
      end else begin
        if (opb[0]) acc <= acc + mcand;
        mcand <= mcand << 1;
        opb   <= opb >> 1;
      end
    end
  end

  assign result    = is_div ? {{W{1'b0}}, acc[W-1:0]} : acc;
  assign remainder = is_div ? acc[2*W-1:W] : '0;

endmodule

// File: rtl/iterative_alu.sv
// Iterative ALU: one-cycle ADD/SUB and divide-by-zero, W-cycle MUL/DIV,
// valid/ready handshake with a single operation in flight.
module iterative_alu
  import alu_pkg::*;
#(
  parameter int W = 8
) (
  input  logic           clk,
  input  logic           rst,
  input  logic           in_valid,
  output logic           in_ready,
  input  logic [W-1:0]   a,
  input  logic [W-1:0]   b,
  input  logic [1:0]     sel,
  output logic           out_valid,
  input  logic           out_ready,
  output logic [2*W-1:0] result,
  output logic [W-1:0]   remainder,
  output logic           div_by_zero
);

  localparam int CW = $clog2(W + 1);

  state_t         state;
  logic [CW-1:0]  iter_cnt;
  logic [2*W-1:0] addsub_q;
  logic           dbz_q;
  logic           accept;
  logic           consume;
  logic           core_done;
  logic [2*W-1:0] core_result;
  logic [W-1:0]   core_rem;

  function automatic logic [2*W-1:0] addsub(input logic [1:0] op, input logic [W-1:0] x,
                                            input logic [W-1:0] y);
    logic [2*W-1:0] xe;
    logic [2*W-1:0] ye;
    xe = {{W{1'b0}}, x};
    ye = {{W{1'b0}}, y};
    if (op == OP_ADD) return xe + ye;
    if (op == OP_SUB) return xe - ye;
    return '0;
  endfunction

  assign in_ready  = (state == IDLE);
  assign out_valid = (state == DONE);
  assign accept    = in_valid && in_ready;
  assign consume   = out_valid && out_ready;

  muldiv_iter_core #(.W(W)) u_core (
    .clk       (clk),
    .rst       (rst),
    .start     (accept),
    .op        (sel),
    .a         (a),
    .b         (b),
    .done      (core_done),
    .result    (core_result),
    .remainder (core_rem)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      state    <= IDLE;
      iter_cnt <= '0;
      dbz_q    <= 1'b0;
    end else begin
      case (state)
        IDLE: if (accept) begin
          state    <= BUSY;
          iter_cnt <= CW'(op_latency(sel, b == '0, W));
          dbz_q    <= (sel == OP_DIV) && (b == '0);
        end
        BUSY: begin
          iter_cnt <= iter_cnt - CW'(1);
          if (iter_cnt == CW'(1)) state <= DONE;
        end
        DONE: if (consume) state <= IDLE;
        default: state <= IDLE;
      endcase
    end
  end

  // ADD/SUB finish at accept; the register just waits out the one BUSY cycle.
  always_ff @(posedge clk) begin
    if (accept) addsub_q <= addsub(sel, a, b);
  end

  // Outputs are forced to zero outside DONE so stale core state never leaks out.
  always_comb begin
    result      = '0;
    remainder   = '0;
    div_by_zero = 1'b0;
    if (out_valid) begin
      div_by_zero = dbz_q;
      if (core_done) begin
        result    = core_result;
        remainder = core_rem;
      end else begin
        result = addsub_q;
      end
    end
  end

endmodule
